// File: rtl/regwrite_arbiter.sv
// Register-file write-port arbiter: two requesters (A = ALU writeback, B = load writeback)
// share one write port through a 4-phase req/ack handshake with round-robin tie breaking,
// a one-cycle write strobe and a saturating conflict counter.
module regwrite_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_a,
  input  logic [SEL_W-1:0]  sel_a,
  input  logic [DATA_W-1:0] data_a,
  output logic              ack_a,
  input  logic              req_b,
  input  logic [SEL_W-1:0]  sel_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              ack_b,
  output logic              wr_en,
  output logic [SEL_W-1:0]  wr_sel,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic [CNT_W-1:0]  conflict_cnt
);

  typedef enum logic [1:0] {StIdle, StWrite, StAck, StWaitDrop} state_t;

  state_t state;
  logic   last_grant;  // 0 = A, 1 = B; resets to B so A wins the first tie
  logic   grant_b;     // requester owning the current transaction

  logic              pick_b;
  logic              both_req;
  logic [SEL_W-1:0]  pick_sel;
  logic [DATA_W-1:0] pick_data;
  logic              granted_req;
  logic              cnt_full;

  // Arbitration decision and handshake-release condition
  always_comb begin
    both_req    = req_a & req_b;
    // On a tie the requester that did not win last time is chosen
    pick_b      = req_b & (~req_a | ~last_grant);
    pick_sel    = pick_b ? sel_b : sel_a;
    pick_data   = pick_b ? data_b : data_a;
    granted_req = grant_b ? req_b : req_a;
    cnt_full    = (conflict_cnt == {CNT_W{1'b1}});
  end

  // Handshake FSM with registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      last_grant   <= 1'b1;
      grant_b      <= 1'b0;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      wr_en        <= 1'b0;
      wr_sel       <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_a | req_b) begin
            grant_b    <= pick_b;
            last_grant <= pick_b;
            wr_sel     <= pick_sel;
            wr_data    <= pick_data;
            // Code 0 is the NOP register: handshake runs but nothing is written
            wr_en      <= (pick_sel != '0);
            busy       <= 1'b1;
            if (both_req && !cnt_full) begin
              conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            state      <= StWrite;
          end
        end
        StWrite: begin
          wr_en <= 1'b0;
          ack_a <= ~grant_b;
          ack_b <= grant_b;
          state <= StAck;
        end
        StAck: begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          state <= StWaitDrop;
        end
        StWaitDrop: begin
          if (!granted_req) begin
            busy  <= 1'b0;
            state <= StIdle;
          end
        end
        default: begin
          wr_en <= 1'b0;
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Self-checking bench for regwrite_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-timing reference model.
module tb_regwrite_arbiter;

  localparam int DW   = 32;
  localparam int SW   = 4;
  localparam int CW   = 8;
  localparam int CMAX = 255;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_a = 1'b0, req_b = 1'b0;
  logic [SW-1:0] sel_a = '0, sel_b = '0;
  logic [DW-1:0] data_a = '0, data_b = '0;
  logic          ack_a, ack_b, wr_en, busy;
  logic [SW-1:0] wr_sel;
  logic [DW-1:0] wr_data;
  logic [CW-1:0] conflict_cnt;

  int total = 0;
  int bad   = 0;

  regwrite_arbiter #(.DATA_W(DW), .SEL_W(SW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .req_a(req_a), .sel_a(sel_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .sel_b(sel_b), .data_b(data_b), .ack_b(ack_b),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .busy(busy), .conflict_cnt(conflict_cnt)
  );

  always #5 clock = ~clock;

  // Reference model: a transaction is described by its grant edge g; the write strobe
  // follows edge g, the ack follows edge g+1, and release is possible from edge g+3 on.
  bit            m_active;
  int            m_who, m_last, m_e, m_g, m_cnt;
  logic [SW-1:0] m_sel;
  logic [DW-1:0] m_data;
  bit            m_wr_en, m_ack_a, m_ack_b, m_busy;

  task automatic model_clear();
    m_active = 0; m_who = 0; m_last = 1; m_g = -100; m_cnt = 0;
    m_sel = '0; m_data = '0;
    m_wr_en = 0; m_ack_a = 0; m_ack_b = 0; m_busy = 0;
  endtask

  task automatic model_edge();
    m_e++;
    if (reset) begin
      model_clear();
      return;
    end
    if (!m_active) begin
      if (req_a || req_b) begin
        if (req_a && req_b) begin
          m_who = (m_last == 1) ? 0 : 1;
          if (m_cnt < CMAX) m_cnt++;
        end else begin
          m_who = req_a ? 0 : 1;
        end
        m_last   = m_who;
        m_active = 1;
        m_g      = m_e;
        m_sel    = (m_who == 1) ? sel_b : sel_a;
        m_data   = (m_who == 1) ? data_b : data_a;
      end
    end else if (m_e >= m_g + 3 && !((m_who == 1) ? req_b : req_a)) begin
      m_active = 0;
    end
    m_busy  = m_active;
    m_wr_en = m_active && (m_e == m_g) && (m_sel != '0);
    m_ack_a = m_active && (m_e == m_g + 1) && (m_who == 0);
    m_ack_b = m_active && (m_e == m_g + 1) && (m_who == 1);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_clear();
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic drain();
    req_a = 1'b0; req_b = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    total += 7;
    if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got %0b want 0", wr_en); end
    if (ack_a !== 1'b0) begin bad++; $display("FAIL reset_ack_a got %0b want 0", ack_a); end
    if (ack_b !== 1'b0) begin bad++; $display("FAIL reset_ack_b got %0b want 0", ack_b); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    if (wr_sel !== '0) begin bad++; $display("FAIL reset_wr_sel got %0h want 0", wr_sel); end
    if (wr_data !== '0) begin bad++; $display("FAIL reset_wr_data got %0h want 0", wr_data); end
    if (conflict_cnt !== '0) begin
      bad++; $display("FAIL reset_cnt got %0d want 0", conflict_cnt);
    end
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_a();
    int ackb_seen = 0;
    req_a = 1'b1; sel_a = 4'h6; data_a = 32'h1234;
    step();
    total += 4;
    if (wr_en !== 1'b1) begin bad++; $display("FAIL single_wr_en got %0b want 1", wr_en); end
    if (wr_sel !== 4'h6) begin bad++; $display("FAIL single_wr_sel got %0h want 6", wr_sel); end
    if (wr_data !== 32'h1234) begin
      bad++; $display("FAIL single_wr_data got %0h want 1234", wr_data);
    end
    if (ack_a !== 1'b0) begin bad++; $display("FAIL single_early_ack got %0b want 0", ack_a); end
    ackb_seen += int'(ack_b);
    step();
    total += 2;
    if (ack_a !== 1'b1) begin bad++; $display("FAIL single_ack_a got %0b want 1", ack_a); end
    if (wr_en !== 1'b0) begin bad++; $display("FAIL single_wr_en_off got %0b want 0", wr_en); end
    ackb_seen += int'(ack_b);
    for (int i = 0; i < 3; i++) begin
      step();
      ackb_seen += int'(ack_b);
      total++;
      if (busy !== 1'b1 || ack_a !== 1'b0) begin
        bad++; $display("FAIL single_hold busy=%0b ack_a=%0b want 1/0", busy, ack_a);
      end
    end
    req_a = 1'b0;
    step();
    ackb_seen += int'(ack_b);
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL single_release got %0b want 0", busy); end
    if (ackb_seen != 0) begin
      bad++; $display("FAIL single_ack_b got %0d pulses want 0", ackb_seen);
    end
    drain();
  endtask

  task automatic test_conflict();
    do_reset();
    sel_a = 4'h1; data_a = 32'hA1; sel_b = 4'h2; data_b = 32'hB2;
    req_a = 1'b1; req_b = 1'b1;
    step();
    total += 2;
    if (wr_sel !== 4'h1) begin bad++; $display("FAIL tie1_winner got %0h want 1", wr_sel); end
    if (conflict_cnt !== 8'd1) begin
      bad++; $display("FAIL tie1_cnt got %0d want 1", conflict_cnt);
    end
    step(); step();
    // A releases for one edge and comes straight back while B is still waiting
    req_a = 1'b0;
    step();
    req_a = 1'b1;
    step();
    total += 2;
    if (wr_sel !== 4'h2) begin bad++; $display("FAIL tie2_winner got %0h want 2", wr_sel); end
    if (conflict_cnt !== 8'd2) begin
      bad++; $display("FAIL tie2_cnt got %0d want 2", conflict_cnt);
    end
    step();
    total++;
    if (ack_b !== 1'b1 || ack_a !== 1'b0) begin
      bad++; $display("FAIL tie2_ack ack_a=%0b ack_b=%0b want 0/1", ack_a, ack_b);
    end
    step();
    req_b = 1'b0;
    step();
    step();
    total += 2;
    if (wr_sel !== 4'h1 || wr_en !== 1'b1) begin
      bad++; $display("FAIL after_b_winner sel=%0h en=%0b want 1/1", wr_sel, wr_en);
    end
    if (conflict_cnt !== 8'd2) begin
      bad++; $display("FAIL after_b_cnt got %0d want 2", conflict_cnt);
    end
    drain();
  endtask

  task automatic test_nop();
    req_b = 1'b1; sel_b = 4'h0; data_b = 32'hDEAD;
    step();
    total++;
    if (wr_en !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL nop_write en=%0b busy=%0b want 0/1", wr_en, busy);
    end
    step();
    total++;
    if (ack_b !== 1'b1 || wr_en !== 1'b0) begin
      bad++; $display("FAIL nop_ack ack_b=%0b en=%0b want 1/0", ack_b, wr_en);
    end
    step();
    req_b = 1'b0;
    step();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL nop_idle got %0b want 0", busy); end
    drain();
  endtask

  task automatic test_reset_mid();
    for (int phase = 1; phase <= 2; phase++) begin
      int stray = 0;
      sel_a = 4'h3; data_a = 32'h55; sel_b = 4'h4; data_b = 32'h66;
      req_a = 1'b1; req_b = 1'b1;
      repeat (phase) step();
      // phase 1 lands in the write cycle, phase 2 in the ack cycle
      #2;
      reset = 1'b1;
      model_clear();
      #1;
      total += 2;
      if (wr_en !== 1'b0 || ack_a !== 1'b0 || ack_b !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL rstmid%0d_outputs en=%0b aa=%0b ab=%0b busy=%0b want 0", phase, wr_en,
                 ack_a, ack_b, busy);
      end
      if (conflict_cnt !== '0) begin
        bad++; $display("FAIL rstmid%0d_cnt got %0d want 0", phase, conflict_cnt);
      end
      step();
      req_a = 1'b0; req_b = 1'b0;
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
        step();
        stray += int'(wr_en) + int'(ack_a) + int'(ack_b) + int'(busy);
      end
      total++;
      if (stray != 0) begin
        bad++; $display("FAIL rstmid%0d_after got %0d activity want 0", phase, stray);
      end
    end
    drain();
  endtask

  task automatic test_saturate();
    do_reset();
    sel_a = 4'h7; sel_b = 4'h8;
    req_a = 1'b1; req_b = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 100 || i == 255 || i == 256) begin
        total++;
        if (conflict_cnt !== 8'(m_cnt)) begin
          bad++; $display("FAIL sat_cnt_%0d got %0d want %0d", i, conflict_cnt, m_cnt);
        end
      end
      step(); step();
      if (m_who == 0) req_a = 1'b0; else req_b = 1'b0;
      step();
      req_a = 1'b1; req_b = 1'b1;
    end
    total++;
    if (conflict_cnt !== 8'd255) begin
      bad++; $display("FAIL sat_final got %0d want 255", conflict_cnt);
    end
    drain();
  endtask

  task automatic test_violation();
    int acks = 0;
    do_reset();
    req_a = 1'b1; sel_a = 4'h5; data_a = 32'hAAAA_0001;
    step();
    req_a = 1'b0; sel_a = 4'h9; data_a = 32'hBBBB_0002;
    step();
    acks += int'(ack_a);
    total += 2;
    if (wr_data !== 32'hAAAA_0001 || wr_sel !== 4'h5) begin
      bad++; $display("FAIL viol_latched got %0h/%0h want 5/aaaa0001", wr_sel, wr_data);
    end
    if (ack_a !== 1'b1) begin bad++; $display("FAIL viol_ack got %0b want 1", ack_a); end
    step();
    acks += int'(ack_a);
    step();
    acks += int'(ack_a);
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL viol_idle got %0b want 0", busy); end
    if (acks != 1) begin bad++; $display("FAIL viol_ack_count got %0d want 1", acks); end
    drain();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) req_a = ~req_a;
      if ($urandom_range(0, 3) == 0) req_b = ~req_b;
      sel_a  = SW'($urandom_range(0, 15));
      sel_b  = SW'($urandom_range(0, 15));
      data_a = $urandom;
      data_b = $urandom;
      step();
      total++;
      if (wr_en !== m_wr_en || ack_a !== m_ack_a || ack_b !== m_ack_b || busy !== m_busy ||
          wr_sel !== m_sel || wr_data !== m_data || conflict_cnt !== 8'(m_cnt)) begin
        bad++;
        $display("FAIL rand_cyc%0d got en=%0b aa=%0b ab=%0b busy=%0b sel=%0h data=%0h cnt=%0d want en=%0b aa=%0b ab=%0b busy=%0b sel=%0h data=%0h cnt=%0d",
                 i, wr_en, ack_a, ack_b, busy, wr_sel, wr_data, conflict_cnt,
                 m_wr_en, m_ack_a, m_ack_b, m_busy, m_sel, m_data, m_cnt);
      end
      total++;
      if ((ack_a && ack_b) || (wr_en && (ack_a || ack_b))) begin
        bad++; $display("FAIL rand_excl_cyc%0d got en=%0b aa=%0b ab=%0b want exclusive", i,
                        wr_en, ack_a, ack_b);
      end
    end
    drain();
  endtask

  initial begin
    m_e = 0;
    model_clear();
    test_reset();
    test_single_a();
    test_conflict();
    test_nop();
    test_reset_mid();
    test_saturate();
    test_violation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
